pom_lock_mgr: RTL and testbench

Multi-port, parametrised lock manager for the OmpSs@FPGA manager. It arbitrates lock/unlock commands from `NUM_PORTS` accelerator command streams and keeps an owner table for `NUM_LOCKS` locks. Each lock request gets an OK/REJECT acknowledgement routed back to the requesting accelerator. It replaces the single-lock, single-port lock path and sits between the HWR lock channel (`HWR_LOCK_ID`) and the accelerator ack stream.

---
 rtl/pom_lock_mgr_pkg.sv | 39 +++
 rtl/pom_lock_mgr_arbiter.sv | 43 ++++
 rtl/pom_lock_mgr.sv | 179 +++++++++++++++++
 tb/tb_pom_lock_mgr.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pom_lock_mgr_pkg.sv
// Shared lock-manager types and command/ack codes for the OmpSs@FPGA manager.
// Command words carry the code in [7:0] and the lock ID in [15:8].
package pom_lock_mgr_pkg;

  localparam int LOCK_ID_BITS    = 8;
  localparam int LOCK_ID_L       = 8;
  localparam int LOCK_ID_H       = 15;
  localparam int LOCK_ACK_CODE_L = 0;
  localparam int LOCK_ACK_CODE_H = 7;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

  // Owner field is sized for the widest supported accelerator ID.
  localparam int LOCK_OWNER_BITS = 16;

  typedef struct packed {
    logic                       held;
    logic [LOCK_OWNER_BITS-1:0] owner;
  } LockEntry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } LockMgrState_t;

  function automatic logic [63:0] lock_ack_word(input logic [7:0]              code,
                                                input logic [LOCK_ID_BITS-1:0] id);
    logic [63:0] w;
    w = '0;
    w[LOCK_ACK_CODE_H:LOCK_ACK_CODE_L] = code;
    w[LOCK_ID_H:LOCK_ID_L]             = id;
    return w;
  endfunction

endpackage

// File: rtl/pom_lock_mgr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting port at or after the
// last grant + 1; the pointer only moves when the grant is taken (advance).
module pom_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] r_last;
  logic             w_found;
  int               w_q;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_q       = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_q = (int'(r_last) + k) % NUM_PORTS;
      if (!w_found && req[w_q]) begin
        w_found        = 1'b1;
        grant[w_q]     = 1'b1;
        grant_idx      = IDX_W'(w_q);
      end
    end
  end

  // Reset pointer to the last port so port 0 has first priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= IDX_W'(NUM_PORTS - 1);
    end else if (advance && w_found) begin
      r_last <= grant_idx;
    end
  end

endmodule

// File: rtl/pom_lock_mgr.sv
// Multi-port lock manager: arbitrates lock/unlock commands, keeps the owner
// table and returns OK/REJECT acks to the requesting accelerator.
module pom_lock_mgr
  import pom_lock_mgr_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int NUM_LOCKS   = 16,
  parameter int ACC_ID_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_PORTS-1:0]           cmd_tvalid,
  output logic [NUM_PORTS-1:0]           cmd_tready,
  input  logic [NUM_PORTS*64-1:0]        cmd_tdata,
  input  logic [NUM_PORTS*ACC_ID_BITS-1:0] cmd_tid,
  output logic                           ack_tvalid,
  input  logic                           ack_tready,
  output logic [63:0]                    ack_tdata,
  output logic [ACC_ID_BITS-1:0]         ack_tdest,
  output logic [NUM_LOCKS-1:0]           locked,
  output logic                           err
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LIDX_W = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  LockMgrState_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_grant, w_arb_idx;
  logic [NUM_PORTS-1:0]      r_grant_oh, w_arb_gnt;
  logic                      w_arb_adv;
  LockEntry_t                r_table [NUM_LOCKS];
  logic [7:0]                w_code;
  logic [LOCK_ID_BITS-1:0]   w_lock_id;
  logic [ACC_ID_BITS-1:0]    w_tid;
  logic                      w_vld;
  logic [LIDX_W-1:0]         w_idx;
  LockEntry_t                w_entry;
  logic                      w_in_range, w_owner_match;
  logic                      w_set_lock, w_clr_lock, w_ack_load, w_err_set;
  logic [7:0]                w_ack_code;
  logic [63:0]               r_ack_data;
  logic [ACC_ID_BITS-1:0]    r_ack_dest;
  logic                      r_err;
  logic                      w_unused;

  assign w_unused = ^cmd_tdata;

  pom_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (cmd_tvalid),
    .advance   (w_arb_adv),
    .grant     (w_arb_gnt),
    .grant_idx (w_arb_idx)
  );

  always_comb begin
    w_code    = '0;
    w_lock_id = '0;
    w_tid     = '0;
    w_vld     = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (IDX_W'(p) == r_grant) begin
        w_code    = cmd_tdata[64*p +: 8];
        w_lock_id = cmd_tdata[64*p+LOCK_ID_L +: LOCK_ID_BITS];
        w_tid     = cmd_tid[ACC_ID_BITS*p +: ACC_ID_BITS];
        w_vld     = cmd_tvalid[p];
      end
    end
  end

  assign w_in_range    = int'(w_lock_id) < NUM_LOCKS;
  assign w_idx         = w_lock_id[LIDX_W-1:0];
  assign w_entry       = r_table[w_idx];
  assign w_owner_match = (w_entry.owner == LOCK_OWNER_BITS'(w_tid));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_oh <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb_adv) begin
        r_grant    <= w_arb_idx;
        r_grant_oh <= w_arb_gnt;
      end
    end
  end

  // One decision in EXEC drives both the table update and the ack word.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_adv   = 1'b0;
    cmd_tready  = '0;
    ack_tvalid  = 1'b0;
    w_set_lock  = 1'b0;
    w_clr_lock  = 1'b0;
    w_ack_load  = 1'b0;
    w_err_set   = 1'b0;
    w_ack_code  = ACK_REJECT_CODE;
    case (r_state)
      IDLE: begin
        if (|cmd_tvalid) begin
          w_arb_adv   = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = IDLE;
        if (w_vld) begin
          cmd_tready = r_grant_oh;
          if (w_code == CMD_LOCK_CODE) begin
            w_state_nxt = ACK;
            w_ack_load  = 1'b1;
            if (!w_in_range) begin
              w_err_set = 1'b1;
            end else if (!w_entry.held) begin
              w_set_lock = 1'b1;
              w_ack_code = ACK_OK_CODE;
            end
          end else if (w_code == CMD_UNLOCK_CODE) begin
            if (w_in_range && w_entry.held && w_owner_match) begin
              w_clr_lock = 1'b1;
            end else begin
              w_err_set = 1'b1;
            end
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ACK: begin
        ack_tvalid = 1'b1;
        if (ack_tready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        r_table[i] <= '0;
      end
      r_ack_data <= '0;
      r_ack_dest <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_set_lock) begin
        r_table[w_idx].held  <= 1'b1;
        r_table[w_idx].owner <= LOCK_OWNER_BITS'(w_tid);
      end
      if (w_clr_lock) begin
        r_table[w_idx].held <= 1'b0;
      end
      if (w_ack_load) begin
        r_ack_data <= lock_ack_word(w_ack_code, w_lock_id);
        r_ack_dest <= w_tid;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LOCKS; i++) begin
      locked[i] = r_table[i].held;
    end
  end

  assign ack_tdata = r_ack_data;
  assign ack_tdest = r_ack_dest;
  assign err       = r_err;

endmodule

// File: tb/tb_pom_lock_mgr.sv
// Directed bench for pom_lock_mgr with a lock-table reference model and
// an every-cycle comparison against the DUT outputs.
module tb_pom_lock_mgr;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   cmd_tvalid;
  logic [3:0]   cmd_tready;
  logic [255:0] cmd_tdata;
  logic [15:0]  cmd_tid;
  logic         ack_tvalid;
  logic         ack_tready;
  logic [63:0]  ack_tdata;
  logic [3:0]   ack_tdest;
  logic [15:0]  locked;
  logic         err;

  int total = 0;
  int bad   = 0;

  pom_lock_mgr #(.NUM_PORTS(4), .NUM_LOCKS(16), .ACC_ID_BITS(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .cmd_tdata  (cmd_tdata),
    .cmd_tid    (cmd_tid),
    .ack_tvalid (ack_tvalid),
    .ack_tready (ack_tready),
    .ack_tdata  (ack_tdata),
    .ack_tdest  (ack_tdest),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lock table, sticky error, pending acks, rr pointer.
  bit          m_held [16];
  logic [3:0]  m_owner [16];
  bit          m_err;
  int          m_last;
  logic [67:0] exp_q [$];
  logic [7:0]  mc, mid, mack;
  logic [3:0]  mt;
  int          ep;
  bit          efound;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        m_held[i]  = 1'b0;
        m_owner[i] = '0;
      end
      m_err  = 1'b0;
      m_last = 3;
      exp_q.delete();
    end else begin
      if (ack_tvalid && ack_tready && exp_q.size() != 0) void'(exp_q.pop_front());
      for (int p = 0; p < 4; p++) begin
        if (cmd_tvalid[p] && cmd_tready[p]) begin
          efound = 1'b0;
          ep = 0;
          for (int k = 1; k <= 4; k++) begin
            if (!efound && cmd_tvalid[(m_last + k) % 4]) begin
              efound = 1'b1;
              ep = (m_last + k) % 4;
            end
          end
          chk("rr_grant", 64'(p), 64'(ep));
          m_last = p;
          mc  = cmd_tdata[64*p +: 8];
          mid = cmd_tdata[64*p+8 +: 8];
          mt  = cmd_tid[4*p +: 4];
          if (mc == 8'h04) begin
            mack = 8'h00;
            if (mid >= 16) m_err = 1'b1;
            else if (!m_held[mid[3:0]]) begin
              m_held[mid[3:0]]  = 1'b1;
              m_owner[mid[3:0]] = mt;
              mack = 8'h01;
            end
            exp_q.push_back({mt, 48'h0, mid, mack});
          end else if (mc == 8'h06) begin
            if (mid < 16 && m_held[mid[3:0]] && m_owner[mid[3:0]] == mt) m_held[mid[3:0]] = 1'b0;
            else m_err = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  logic [15:0] lv;
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 16; i++) lv[i] = m_held[i];
      chk("locked", 64'(locked), 64'(lv));
      chk("err", 64'(err), 64'(m_err));
      chk("ack_vld", 64'(ack_tvalid), 64'(exp_q.size() != 0));
      chk("rdy_onehot0", 64'($onehot0(cmd_tready)), 64'(1));
      if (ack_tvalid && exp_q.size() != 0) begin
        chk("ack_data", ack_tdata, exp_q[0][63:0]);
        chk("ack_dest", 64'(ack_tdest), 64'(exp_q[0][67:64]));
        chk("rdy_while_ack", 64'(cmd_tready), 64'(0));
      end
    end
  end

  logic [19:0] got [$];
  always @(negedge clk) begin
    if (rstn && ack_tvalid && ack_tready) got.push_back({ack_tdest, ack_tdata[15:0]});
  end

  task automatic set_cmd(input int p, input logic [3:0] tid, input logic [7:0] code,
                         input logic [7:0] id);
    cmd_tdata[64*p +: 64] = {48'h0, id, code};
    cmd_tid[4*p +: 4]     = tid;
  endtask

  task automatic run(input logic [3:0] mask);
    logic [3:0] pend, acc;
    int n;
    pend = mask;
    cmd_tvalid = cmd_tvalid | mask;
    n = 0;
    while (pend != 0 && n < 40) begin
      @(negedge clk);
      acc = cmd_tready & pend & cmd_tvalid;
      @(posedge clk); #1;
      cmd_tvalid = cmd_tvalid & ~acc;
      pend = pend & ~acc;
      n++;
    end
    chk("accept_pending", 64'(pend), 64'(0));
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_tvalid = '0;
    cmd_tdata  = '0;
    cmd_tid    = '0;
    ack_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    chk("rst_ready", 64'(cmd_tready), 64'(0));
    chk("rst_ackv", 64'(ack_tvalid), 64'(0));
    chk("rst_ackd", ack_tdata, 64'(0));
    chk("rst_dest", 64'(ack_tdest), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_err", 64'(err), 64'(0));

    // Lock path timing: port 0, tid 3, lock 5.
    got.delete();
    set_cmd(0, 4'd3, 8'h04, 8'd5);
    @(posedge clk); #1;
    cmd_tvalid[0] = 1'b1;
    @(negedge clk);
    chk("t1_c0_rdy", 64'(cmd_tready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_c1_rdy", 64'(cmd_tready), 64'(1));
    chk("t1_c1_ackv", 64'(ack_tvalid), 64'(0));
    @(posedge clk); #1;
    cmd_tvalid[0] = 1'b0;
    @(negedge clk);
    chk("t1_c2_ackv", 64'(ack_tvalid), 64'(1));
    chk("t1_c2_data", ack_tdata, 64'h0501);
    chk("t1_c2_dest", 64'(ack_tdest), 64'(3));
    chk("t1_locked5", 64'(locked[5]), 64'(1));
    settle(3);

    // Owner unlock: no ack, lock released.
    got.delete();
    set_cmd(0, 4'd3, 8'h06, 8'd5);
    run(4'b0001);
    settle(3);
    chk("unl_locked5", 64'(locked[5]), 64'(0));
    chk("unl_err", 64'(err), 64'(0));
    chk("unl_noack", 64'(got.size()), 64'(0));

    // Foreign unlock of lock 9 held by tid 2.
    set_cmd(3, 4'd2, 8'h04, 8'd9);
    run(4'b1000);
    settle(3);
    set_cmd(1, 4'd4, 8'h06, 8'd9);
    run(4'b0010);
    settle(3);
    chk("foreign_locked9", 64'(locked[9]), 64'(1));
    chk("foreign_err", 64'(err), 64'(1));

    // Out-of-range lock ID.
    do_reset();
    got.delete();
    set_cmd(2, 4'd1, 8'h04, 8'd20);
    run(4'b0100);
    settle(3);
    chk("oor_n", 64'(got.size()), 64'(1));
    chk("oor_ack", 64'(got[0]), 64'h1_1400);
    chk("oor_err", 64'(err), 64'(1));

    // Unknown command code.
    do_reset();
    got.delete();
    set_cmd(1, 4'd1, 8'h09, 8'd2);
    run(4'b0010);
    settle(3);
    chk("bad_code_noack", 64'(got.size()), 64'(0));
    chk("bad_code_err", 64'(err), 64'(1));

    // Ack back-pressure with a second command waiting.
    do_reset();
    set_cmd(3, 4'd2, 8'h04, 8'd9);
    run(4'b1000);
    settle(3);
    ack_tready = 1'b0;
    set_cmd(2, 4'd5, 8'h04, 8'd3);
    run(4'b0100);
    set_cmd(0, 4'd1, 8'h04, 8'd11);
    cmd_tvalid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ackv", 64'(ack_tvalid), 64'(1));
      chk("stall_data", ack_tdata, 64'h0301);
      chk("stall_dest", 64'(ack_tdest), 64'(5));
      chk("stall_rdy", 64'(cmd_tready), 64'(0));
    end
    @(posedge clk); #1;
    ack_tready = 1'b1;
    run(4'b0001);
    settle(3);
    chk("held_3", 64'(locked), 64'h0A08);

    // Reset while an ack is pending with three locks held.
    ack_tready = 1'b0;
    set_cmd(1, 4'd7, 8'h04, 8'd9);
    run(4'b0010);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ackv", 64'(ack_tvalid), 64'(0));
    chk("arst_data", ack_tdata, 64'(0));
    chk("arst_dest", 64'(ack_tdest), 64'(0));
    chk("arst_locked", 64'(locked), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_rdy", 64'(cmd_tready), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    ack_tready = 1'b1;

    // Port 0 wins first after reset; same lock re-acquired.
    got.delete();
    set_cmd(0, 4'd6, 8'h04, 8'd9);
    set_cmd(1, 4'd7, 8'h04, 8'd9);
    run(4'b0011);
    settle(4);
    chk("post_rst_n", 64'(got.size()), 64'(2));
    chk("post_rst_ok", 64'(got[0]), 64'h6_0901);
    chk("post_rst_rej", 64'(got[1]), 64'h7_0900);

    // Ports 1 and 2 race for lock 7 right after reset.
    do_reset();
    got.delete();
    set_cmd(1, 4'd1, 8'h04, 8'd7);
    set_cmd(2, 4'd2, 8'h04, 8'd7);
    run(4'b0110);
    settle(4);
    chk("race_n", 64'(got.size()), 64'(2));
    chk("race_ok", 64'(got[0]), 64'h1_0701);
    chk("race_rej", 64'(got[1]), 64'h2_0700);
    chk("race_locked", 64'(locked), 64'h0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
